// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: RV32I funct3
//               codes, FSM state type and lane-mask helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RV32I load funct3 codes
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    // RV32I store funct3 codes
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Byte-enable pattern of an access before it is shifted into its lane.
    function automatic logic [3:0] base_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Offset of the last byte touched, relative to the first one.
    function automatic logic [1:0] last_byte_ofs(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return (funct3 == c_f3_sb) || (funct3 == c_f3_sh) || (funct3 == c_f3_sw);
        else
            return (funct3 == c_f3_lb)  || (funct3 == c_f3_lh) || (funct3 == c_f3_lw) ||
                   (funct3 == c_f3_lbu) || (funct3 == c_f3_lhu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load alignment: shifts the {hi, lo} word pair
//               down by the byte offset and sign/zero-extends per funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    logic [31:0] w_word;

    // Only the low 32 bits of the shifted pair are ever needed
    assign w_word = 32'({i_hi, i_lo} >> {i_off, 3'b000});

    // Extend the selected byte/half to a full word
    always_comb begin
        o_rdata = w_word;
        case (i_funct3)
            c_f3_lb:  o_rdata = {{24{w_word[7]}}, w_word[7:0]};
            c_f3_lbu: o_rdata = {24'd0, w_word[7:0]};
            c_f3_lh:  o_rdata = {{16{w_word[15]}}, w_word[15:0]};
            c_f3_lhu: o_rdata = {16'd0, w_word[15:0]};
            default:  o_rdata = w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit driving a word-addressed, byte-enabled data
//               memory. One request in flight; byte masks, lane-shifted store
//               data and extended load data. Word-crossing accesses are split
//               into two word accesses when LSU_MISALIGN_SPLIT_EN is defined,
//               otherwise they complete with an error and no memory strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [31:0] o_data_addr,
    input  logic [31:0] i_data_rd_data,
    output logic [31:0] o_data_wr_data,
    output logic [3:0]  o_data_size,
    output logic        o_data_write,
    output logic        o_data_read
);

    lsu_state_t r_state, w_state_nxt;

    // Decode of the incoming request, used at the acceptance edge
    logic [1:0]  w_off;
    logic [7:0]  w_mask8;
    logic        w_cross;
    logic [32:0] w_last;
    logic        w_oor;
    logic        w_err;
    logic [31:0] w_wdata0;
    logic        w_accept;

    assign w_accept = i_req_valid && (r_state == IDLE);
    assign w_off    = i_req_addr[1:0];
    assign w_mask8  = {4'b0000, base_mask(i_req_funct3)} << w_off;
    assign w_cross  = |w_mask8[7:4];
    // 33-bit sum so an access running past 2**32 is still seen as out of range
    assign w_last   = {1'b0, i_req_addr} + {31'd0, last_byte_ofs(i_req_funct3)};
    assign w_oor    = |(w_last >> MEM_ADDR_WIDTH);

    // Captured request
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_err;

    // Registered outputs
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_size;
    logic        r_write_stb, r_read_stb, r_rsp_valid, r_rsp_err;

    // Next values of the registered outputs
    logic [31:0] w_addr_nxt, w_wdata_nxt;
    logic [3:0]  w_size_nxt;
    logic        w_write_nxt, w_read_nxt, w_rsp_valid_nxt, w_rsp_err_nxt;

    logic [31:0] w_hi, w_lo, w_load;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [63:0] w_data64;
    logic        r_split;
    logic [29:0] r_word_hi;
    logic [3:0]  r_mask_hi;
    logic [31:0] r_data_hi;
    logic [31:0] r_lo;

    assign w_data64 = {32'd0, i_req_wdata} << {w_off, 3'b000};
    assign w_wdata0 = w_data64[31:0];
    assign w_err    = !funct3_legal(i_req_write, i_req_funct3) || w_oor;

    // Second-word parameters of a split access, held for the ACC1 beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_split   <= 1'b0;
            r_word_hi <= '0;
            r_mask_hi <= '0;
            r_data_hi <= '0;
        end else if (w_accept) begin
            r_split   <= w_cross && !w_err;
            r_word_hi <= i_req_addr[31:2];
            r_mask_hi <= w_mask8[7:4];
            r_data_hi <= w_data64[63:32];
        end
    end

    // The first read word returns while the second read is on the bus
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_lo <= '0;
        else if (r_state == ACC1)
            r_lo <= i_data_rd_data;
    end

    assign w_hi = r_split ? i_data_rd_data : 32'd0;
    assign w_lo = r_split ? r_lo : i_data_rd_data;
`else
    assign w_wdata0 = i_req_wdata << {w_off, 3'b000};
    assign w_err    = !funct3_legal(i_req_write, i_req_funct3) || w_oor || w_cross;
    assign w_hi     = 32'd0;
    assign w_lo     = i_data_rd_data;
`endif

    // Capture the request fields needed after acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write  <= 1'b0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_write  <= i_req_write;
            r_funct3 <= i_req_funct3;
            r_off    <= w_off;
            r_err    <= w_err;
        end
    end

    // State register and registered memory/response outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_write_stb <= 1'b0;
            r_read_stb  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_size      <= w_size_nxt;
            r_write_stb <= w_write_nxt;
            r_read_stb  <= w_read_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // Next state and next output values; memory outputs return to 0 when idle
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = '0;
        w_wdata_nxt     = '0;
        w_size_nxt      = '0;
        w_write_nxt     = 1'b0;
        w_read_nxt      = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ACC0;
                    w_addr_nxt  = {i_req_addr[31:2], 2'b00};
                    w_size_nxt  = w_mask8[3:0];
                    w_wdata_nxt = w_wdata0;
                    w_write_nxt = i_req_write && !w_err;
                    w_read_nxt  = !i_req_write && !w_err;
                end
            end
            ACC0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (r_split) begin
                    w_state_nxt = ACC1;
                    w_addr_nxt  = {r_word_hi + 30'd1, 2'b00};
                    w_size_nxt  = r_mask_hi;
                    w_wdata_nxt = r_data_hi;
                    w_write_nxt = r_write;
                    w_read_nxt  = !r_write;
                end else
`endif
                begin
                    w_state_nxt     = RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = r_err;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC1: begin
                w_state_nxt     = RESP;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_err_nxt   = r_err;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    lsu_load_align u_load_align (
        .i_hi     (w_hi),
        .i_lo     (w_lo),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_rdata  (w_load)
    );

    assign o_req_ready    = (r_state == IDLE);
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_err      = r_rsp_err;
    assign o_rsp_rdata    = (r_state == RESP && !r_write && !r_err) ? w_load : 32'd0;
    assign o_data_addr    = r_addr;
    assign o_data_wr_data = r_wdata;
    assign o_data_size    = r_size;
    assign o_data_write   = r_write_stb;
    assign o_data_read    = r_read_stb;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Self-checking bench for lsu. A byte-level reference model
//               predicts each response into a queue; a monitor pops and
//               compares on every o_rsp_valid. A word memory model serves the
//               DUT's data port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam int MEM_BYTES = 4096;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [2:0]  i_req_funct3 = '0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [31:0] o_data_addr;
    logic [31:0] i_data_rd_data = '0;
    logic [31:0] o_data_wr_data;
    logic [3:0]  o_data_size;
    logic        o_data_write;
    logic        o_data_read;

    lsu #(.MEM_ADDR_WIDTH(12)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_write    (i_req_write),
        .i_req_funct3   (i_req_funct3),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_data_addr    (o_data_addr),
        .i_data_rd_data (i_data_rd_data),
        .o_data_wr_data (o_data_wr_data),
        .o_data_size    (o_data_size),
        .o_data_write   (o_data_write),
        .o_data_read    (o_data_read)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nstr;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          strobe_cnt = 0;
    time         accept_t = 0;
    logic [31:0] tb_mem [0:1023];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory: reads return the next cycle, writes commit at the edge
    always @(posedge i_clk) begin
        if (o_data_read || o_data_write) begin
            if (o_data_addr >= MEM_BYTES) begin
                errors++;
                $display("FAIL mem_range: strobe at 0x%08h", o_data_addr);
            end
        end
        if (o_data_read)
            i_data_rd_data <= tb_mem[o_data_addr[11:2]];
        if (o_data_write)
            for (int b = 0; b < 4; b++)
                if (o_data_size[b])
                    tb_mem[o_data_addr[11:2]][8*b +: 8] <= o_data_wr_data[8*b +: 8];
    end

    // Response monitor: compares each response to the oldest prediction
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n) begin
            if (o_data_write || o_data_read)
                strobe_cnt++;
            if (o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got a response, none predicted");
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
                    chk("rsp_rdata", o_rsp_rdata, e.rdata);
                    chk("rsp_latency", int'(($time - accept_t + 5) / 10), e.lat);
                    chk("rsp_strobes", strobe_cnt, e.nstr);
                end
            end else begin
                chk("rdata_idle", o_rsp_rdata, 32'd0);
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        exp_t        e;
        int          n, off, budget;
        logic        legal, err, split;
        logic [3:0]  m0, m1;
        logic [31:0] wa, v;
        logic [63:0] wsh;
        budget = 0;
        @(negedge i_clk);
        while (!o_req_ready && budget < 20) begin
            @(negedge i_clk);
            budget++;
        end
        if (!o_req_ready) begin
            chk("ready_timeout", {31'd0, o_req_ready}, 32'd1);
            return;
        end
        i_req_valid  = 1'b1;
        i_req_write  = wr;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        @(posedge i_clk);
        accept_t   = $time;
        strobe_cnt = 0;

        // Reference model: byte-level view of the request
        case (f3[1:0])
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        off   = int'(addr[1:0]);
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || (longint'(addr) + n - 1 >= MEM_BYTES) || (!SPLIT && off + n > 4);
        split = !err && (off + n > 4);
        v = 0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (wr) ref_mem[addr + i] = wd[8*i +: 8];
                else    v[8*i +: 8] = ref_mem[addr + i];
            end
            if (!wr && !f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!wr && !f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        end
        e.rdata = wr ? 32'd0 : v;
        e.err   = err;
        e.lat   = split ? 3 : 2;
        e.nstr  = err ? 0 : (split ? 2 : 1);
        exp_q.push_back(e);

        m0 = '0;
        m1 = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 4) m0[off + i] = 1'b1;
            else             m1[off + i - 4] = 1'b1;
        wa  = {addr[31:2], 2'b00};
        wsh = {32'd0, wd} << (8 * off);

        // Inputs are don't-care after acceptance
        #1;
        i_req_valid  = 1'b0;
        i_req_write  = 1'($urandom);
        i_req_funct3 = 3'($urandom);
        i_req_addr   = $urandom;
        i_req_wdata  = $urandom;

        chk("acc0_write", {31'd0, o_data_write}, {31'd0, wr && !err});
        chk("acc0_read", {31'd0, o_data_read}, {31'd0, !wr && !err});
        if (!err) begin
            chk("acc0_addr", o_data_addr, wa);
            chk("acc0_size", {28'd0, o_data_size}, {28'd0, m0});
            if (wr) chk("acc0_wdata", o_data_wr_data, wsh[31:0]);
        end
        if (split) begin
            @(posedge i_clk);
            #1;
            chk("acc1_addr", o_data_addr, wa + 32'd4);
            chk("acc1_size", {28'd0, o_data_size}, {28'd0, m1});
            chk("acc1_write", {31'd0, o_data_write}, {31'd0, wr});
            chk("acc1_read", {31'd0, o_data_read}, {31'd0, !wr});
            if (wr) chk("acc1_wdata", o_data_wr_data, wsh[63:32]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, o_req_ready}, 32'd1);
        chk({tag, "_addr"}, o_data_addr, 32'd0);
        chk({tag, "_wdata"}, o_data_wr_data, 32'd0);
        chk({tag, "_size"}, {28'd0, o_data_size}, 32'd0);
        chk({tag, "_strobes"}, {30'd0, o_data_write, o_data_read}, 32'd0);
        chk({tag, "_rsp"}, {30'd0, o_rsp_valid, o_rsp_err}, 32'd0);
        chk({tag, "_rdata"}, o_rsp_rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [2:0]  f3;
        logic [31:0] a;
        int          budget;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            tb_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end

        repeat (3) @(negedge i_clk);
        chk_reset_outputs("reset");
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk_reset_outputs("idle");

        // Directed cases
        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        issue(1'b1, 3'b001, 32'h102, 32'h00001234);
        issue(1'b1, 3'b010, 32'h0FC, 32'hAABBCCDD);
        issue(1'b1, 3'b010, 32'h100, 32'h11223344);
        issue(1'b0, 3'b010, 32'h0FE, 32'h0);
        issue(1'b0, 3'b010, 32'h1000, 32'h0);
        issue(1'b0, 3'b011, 32'h010, 32'h0);
        issue(1'b1, 3'b001, 32'hFFF, 32'h5555);
        issue(1'b1, 3'b010, 32'h000, 32'h01234567);

        // Reset during ACC0 of a store: write is dropped, no response
        @(negedge i_clk);
        budget = 0;
        while (!o_req_ready && budget < 20) begin
            @(negedge i_clk);
            budget++;
        end
        i_req_valid  = 1'b1;
        i_req_write  = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h0;
        i_req_wdata  = 32'hFFFFFFFF;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        chk("rst_acc0_write", {31'd0, o_data_write}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1 chk("rst_write_drop", {31'd0, o_data_write}, 32'd0);
        @(negedge i_clk);
        chk_reset_outputs("rst_mid");
        #2 i_rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h000, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'(MEM_BYTES - $urandom_range(0, 7));
                1:       a = $urandom;
                default: a = $urandom_range(0, MEM_BYTES - 1);
            endcase
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else                           f3 = 3'($urandom_range(0, 2));
            if (f3 < 3'd2 && $urandom_range(0, 1) == 1) f3 = f3 + 3'd4;
            if (f3[2] && $urandom_range(0, 1) == 0)
                issue(1'b0, f3, a, $urandom);
            else
                issue(1'($urandom), f3, a, $urandom);
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(negedge i_clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
